// File: rtl/dcm_pkg.sv
// Shared definitions for the DCM supervisor: state codes, frequency windows, reset limits.
// No logic; constants only.
// No flow control.
package dcm_pkg;

  // Debug state codes, also driven on the STATE output
  typedef enum logic [2:0] {
    S_RST  = 3'd0,
    S_WAIT = 3'd1,
    S_MEAS = 3'd2,
    S_RUN  = 3'd3,
    S_FAIL = 3'd4
  } state_e;

  // The DCM needs RST high for at least three CLKIN cycles
  localparam int unsigned RST_CYCLES_MIN = 3;

  // Accepted FX_TOG transition counts per 1024-cycle window at 66 MHz CLKIN
  // 30 MHz product: 1024 * 30 / 66 ~= 465
  localparam int unsigned FX_MIN_30M  = 455;
  localparam int unsigned FX_MAX_30M  = 475;
  // 120 MHz product: 1024 * 120 / 66 ~= 1862
  localparam int unsigned FX_MIN_120M = 1840;
  localparam int unsigned FX_MAX_120M = 1884;

endpackage

// File: rtl/fx_edge_counter.sv
// Counts CLKFX toggle-flop transitions seen in the CLK domain over a gated window.
// Three-flop synchroniser, so an FX_TOG transition is counted 2-3 CLK cycles later.
// No flow control; count saturates at all-ones instead of wrapping.
module fx_edge_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             fx_tog_i,
  input  logic             gate_i,
  input  logic             clr_i,
  input  logic             latch_i,
  output logic [CNT_W-1:0] win_cnt_o,
  output logic [CNT_W-1:0] fx_count_o
);

  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [2:0]       sync_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] fx_count_q;
  logic             edge_w;

  // A transition is a difference between synchroniser stages 2 and 3
  assign edge_w = sync_q[1] ^ sync_q[2];

  // Running count including this cycle's edge, held at all-ones once full
  assign cnt_d = (gate_i && edge_w && (cnt_q != '1)) ? (cnt_q + ONE) : cnt_q;

  assign win_cnt_o  = cnt_d;
  assign fx_count_o = fx_count_q;

  // Bring the asynchronous toggle into the CLK domain
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sync_q <= 3'b000;
    end else begin
      sync_q <= {sync_q[1:0], fx_tog_i};
    end
  end

  // Window counter: clear wins, latch publishes the window total and restarts counting
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q      <= '0;
      fx_count_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (latch_i) begin
      cnt_q      <= '0;
      fx_count_q <= cnt_d;
    end else if (gate_i) begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/dcm_supervisor.sv
// Sequences DCM reset, waits for lock, proves CLKFX frequency, then raises READY; gives up after MAX_RETRY.
// All outputs registered; lock/stop changes act 3 cycles after the pin, window verdict 1 cycle after the last gate cycle.
// No flow control; RESTART pulse overrides any other event in the same cycle.
module dcm_supervisor
  import dcm_pkg::*;
#(
  parameter int unsigned RST_CYCLES   = 4,
  parameter int unsigned LOCK_TIMEOUT = 65535,
  parameter int unsigned GATE_CYCLES  = 1024,
  parameter int unsigned FX_MIN       = FX_MIN_30M,
  parameter int unsigned FX_MAX       = FX_MAX_30M,
  parameter int unsigned MAX_RETRY    = 7,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             locked_i,
  input  logic             clkin_stop_i,
  input  logic             fx_tog_i,
  input  logic             restart_i,
  output logic             dcm_rst_o,
  output logic             ready_o,
  output logic             fault_o,
  output logic [2:0]       retries_o,
  output logic [CNT_W-1:0] fx_count_o,
  output logic [2:0]       state_o
);

  // Never hold DCM reset for less than the part's minimum
  localparam int unsigned RST_EFF = (RST_CYCLES < RST_CYCLES_MIN) ? RST_CYCLES_MIN : RST_CYCLES;

  localparam logic [CNT_W-1:0] ONE          = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_EFF - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] GATE_LAST    = CNT_W'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0] FX_MIN_C     = CNT_W'(FX_MIN);
  localparam logic [CNT_W-1:0] FX_MAX_C     = CNT_W'(FX_MAX);
  localparam logic [2:0]       RETRY_MAX    = 3'(MAX_RETRY);

  logic [1:0]       lk_sync_q;
  logic [1:0]       st_sync_q;
  state_e           state_q;
  logic [CNT_W-1:0] timer_q;
  logic             dcm_rst_q;
  logic             ready_q;
  logic             fault_q;
  logic [2:0]       retries_q;

  logic             lock_ok;
  logic             gated;
  logic             last_gate;
  logic             cnt_ok;
  logic             fail_evt;
  logic [CNT_W-1:0] win_cnt;
  logic             cnt_clr;
  logic             cnt_latch;

  // LOCKED and STATUS[1] are asynchronous to CLK
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      lk_sync_q <= 2'b00;
      st_sync_q <= 2'b00;
    end else begin
      lk_sync_q <= {lk_sync_q[0], locked_i};
      st_sync_q <= {st_sync_q[0], clkin_stop_i};
    end
  end

  assign lock_ok   = lk_sync_q[1] && !st_sync_q[1];
  assign gated     = (state_q == S_MEAS) || (state_q == S_RUN);
  assign last_gate = gated && (timer_q == GATE_LAST);
  assign cnt_ok    = (win_cnt >= FX_MIN_C) && (win_cnt <= FX_MAX_C);

  // Lock loss beats window completion; in S_WAIT a lock in the timeout cycle is not a failure
  assign fail_evt = ((state_q == S_WAIT) && !lock_ok && (timer_q == TIMEOUT_LAST)) ||
                    (gated && (!lock_ok || (last_gate && !cnt_ok)));

  // Counter only runs while a window is open; RESTART discards the window in progress
  assign cnt_clr   = restart_i || !gated;
  assign cnt_latch = last_gate && !restart_i;

  fx_edge_counter #(
    .CNT_W (CNT_W)
  ) u_fx_cnt (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .fx_tog_i   (fx_tog_i),
    .gate_i     (gated),
    .clr_i      (cnt_clr),
    .latch_i    (cnt_latch),
    .win_cnt_o  (win_cnt),
    .fx_count_o (fx_count_o)
  );

  // Supervisor sequence: reset pulse, lock wait, measurement, run, give-up
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= S_RST;
      timer_q   <= '0;
      dcm_rst_q <= 1'b1;
      ready_q   <= 1'b0;
      fault_q   <= 1'b0;
      retries_q <= 3'd0;
    end else if (restart_i) begin
      state_q   <= S_RST;
      timer_q   <= '0;
      dcm_rst_q <= 1'b1;
      ready_q   <= 1'b0;
      fault_q   <= 1'b0;
      retries_q <= 3'd0;
    end else if (fail_evt) begin
      timer_q   <= '0;
      dcm_rst_q <= 1'b1;
      ready_q   <= 1'b0;
      if (retries_q == RETRY_MAX) begin
        state_q <= S_FAIL;
        fault_q <= 1'b1;
      end else begin
        state_q   <= S_RST;
        retries_q <= retries_q + 3'd1;
      end
    end else begin
      case (state_q)
        S_RST: begin
          if (timer_q == RST_LAST) begin
            state_q   <= S_WAIT;
            dcm_rst_q <= 1'b0;
            timer_q   <= '0;
          end else begin
            timer_q <= timer_q + ONE;
          end
        end
        S_WAIT: begin
          if (lock_ok) begin
            state_q <= S_MEAS;
            timer_q <= '0;
          end else begin
            timer_q <= timer_q + ONE;
          end
        end
        S_MEAS, S_RUN: begin
          if (last_gate) begin
            state_q <= S_RUN;
            ready_q <= 1'b1;
            timer_q <= '0;
          end else begin
            timer_q <= timer_q + ONE;
          end
        end
        S_FAIL: begin
          dcm_rst_q <= 1'b1;
          fault_q   <= 1'b1;
        end
        default: begin
          state_q   <= S_RST;
          timer_q   <= '0;
          dcm_rst_q <= 1'b1;
          ready_q   <= 1'b0;
        end
      endcase
    end
  end

  assign dcm_rst_o = dcm_rst_q;
  assign ready_o   = ready_q;
  assign fault_o   = fault_q;
  assign retries_o = retries_q;
  assign state_o   = state_q;

endmodule
